matrix_mult_vector: RTL and testbench

MATRIX_MULT_VECTOR -- requirements
Module: matrix_mult_vector

---
 rtl/matrix_mult_vector.sv | 142 ++++++++++++++
 tb/tb_matrix_mult_vector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_vector.sv
// Matrix-vector multiplier: one multiply-accumulate per clock over latched
// operands. Results are published all at once on the completion edge, so the
// output never shows partial sums.
//
// state | meaning
// IDLE  | waiting for i_calc after reset
// BUSY  | stepping through the N multiply-accumulates
// DONE  | result valid and held; i_calc restarts
module matrix_mult_vector #(
  parameter int MATRIX_WIDTH  = 2,
  parameter int MATRIX_HEIGHT = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int MATRIX_WEIGHT = MATRIX_WIDTH * MATRIX_HEIGHT
) (
  input  logic                                clk,
  input  logic                                i_rst,
  input  logic                                i_calc,
  input  logic [MATRIX_WEIGHT*DATA_WIDTH-1:0] i_matrix,
  input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]  i_vector,
  output logic [MATRIX_WEIGHT*DATA_WIDTH-1:0] o_result,
  output logic                                o_ready
);

  localparam int W  = MATRIX_WIDTH;
  localparam int H  = MATRIX_HEIGHT;
  localparam int DW = DATA_WIDTH;
  localparam int N  = MATRIX_WEIGHT;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [N*DW-1:0]     mat_q;
  logic [W*DW-1:0]     vec_q;
  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [DW-1:0]       acc_q [H];
  logic [N*DW-1:0]     result_q;
  logic                ready_q;

  logic [DW-1:0]       m_sel;
  logic [DW-1:0]       v_sel;
  logic [DW-1:0]       acc_sel;
  logic [DW-1:0]       mac_sum_d;
  logic [N*DW-1:0]     result_d;
  logic                last_col;
  logic                last_mac;

  // Select the current operands/accumulator and form the next partial sum;
  // the product is truncated to DW bits, giving modulo-2^DW accumulation.
  always_comb begin
    m_sel   = '0;
    v_sel   = '0;
    acc_sel = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (row_q == RW'(r) && col_q == CW'(c)) begin
          m_sel = mat_q[(r*W+c)*DW +: DW];
        end
      end
      if (row_q == RW'(r)) begin
        acc_sel = acc_q[r];
      end
    end
    for (int c = 0; c < W; c++) begin
      if (col_q == CW'(c)) begin
        v_sel = vec_q[c*DW +: DW];
      end
    end
    mac_sum_d = acc_sel + m_sel * v_sel;
    last_col  = (col_q == CW'(W-1));
    last_mac  = last_col && (row_q == RW'(H-1));
  end

  // Packed result image including the MAC of the current cycle; slots at and
  // above H stay zero.
  always_comb begin
    result_d = '0;
    for (int r = 0; r < H; r++) begin
      result_d[r*DW +: DW] = (row_q == RW'(r)) ? mac_sum_d : acc_q[r];
    end
  end

  // Sequencer, operand latches, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      mat_q    <= '0;
      vec_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      for (int r = 0; r < H; r++) begin
        acc_q[r] <= '0;
      end
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_calc) begin
            mat_q   <= i_matrix;
            vec_q   <= i_vector;
            col_q   <= '0;
            row_q   <= '0;
            for (int r = 0; r < H; r++) begin
              acc_q[r] <= '0;
            end
            ready_q <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          for (int r = 0; r < H; r++) begin
            if (row_q == RW'(r)) begin
              acc_q[r] <= mac_sum_d;
            end
          end
          if (last_mac) begin
            result_q <= result_d;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end else if (last_col) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_result = result_q;
  assign o_ready  = ready_q;

endmodule

// File: tb/tb_matrix_mult_vector.sv
// Directed bench for matrix_mult_vector at default parameters. Stimulus pushes
// the hand-computed result and its due cycle; a monitor pops on each rising
// o_ready and compares value and arrival time.
module tb_matrix_mult_vector;

  localparam int N = 4;

  logic        clk;
  logic        i_rst;
  logic        i_calc;
  logic [31:0] i_matrix;
  logic [15:0] i_vector;
  logic [31:0] o_result;
  logic        o_ready;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic ready_prev = 1'b0;

  matrix_mult_vector dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_calc   (i_calc),
    .i_matrix (i_matrix),
    .i_vector (i_vector),
    .o_result (o_result),
    .o_ready  (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge of o_ready.
  always @(negedge clk) begin
    if (o_ready && !ready_prev) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", o_result, e.res);
        chk("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
    ready_prev = o_ready;
  end

  // Pulse i_calc for one cycle and confirm o_ready stays low and the old
  // result holds across the BUSY cycles.
  task automatic run_calc(input logic [31:0] m, input logic [15:0] v,
                          input logic [31:0] exp, input logic [31:0] prev);
    exp_t e;
    @(negedge clk);
    i_matrix = m;
    i_vector = v;
    i_calc   = 1'b1;
    e.res = exp;
    e.due = cyc + 1 + N;
    sb_q.push_back(e);
    @(negedge clk);
    i_calc = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k != 0) @(negedge clk);
      chk("busy_ready_low", {31'd0, o_ready}, 32'd0);
      chk("busy_result_hold", o_result, prev);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      chk("completion_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int s;
    exp_t e;
    i_rst    = 1'b1;
    i_calc   = 1'b0;
    i_matrix = '0;
    i_vector = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, o_ready}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    i_rst = 1'b0;

    // Row 0 wraps 256 -> 0, row 1 = 62.
    run_calc(32'h0203_060E, 16'h0A0E, 32'h0000_3E00, 32'h0);
    wait_done();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_ready_hold", {31'd0, o_ready}, 32'd1);
      chk("done_result_hold", o_result, 32'h0000_3E00);
    end

    // 17 and 39; previous result must hold during BUSY.
    run_calc(32'h0403_0201, 16'h0605, 32'h0000_2711, 32'h0000_3E00);
    wait_done();

    // Operands and i_calc disturbed during BUSY: result from latched 2,0,0,3 x 7,9.
    @(negedge clk);
    i_matrix = 32'h0300_0002;
    i_vector = 16'h0907;
    i_calc   = 1'b1;
    e.res = 32'h0000_1B0E;
    e.due = cyc + 1 + N;
    sb_q.push_back(e);
    @(negedge clk);
    i_matrix = 32'hFFFF_FFFF;
    i_vector = 16'hFFFF;
    i_calc   = 1'b1;
    @(negedge clk);
    i_calc = 1'b0;
    @(negedge clk);
    i_calc = 1'b1;
    @(negedge clk);
    i_calc = 1'b0;
    chk("disturb_busy_ready_low", {31'd0, o_ready}, 32'd0);
    wait_done();

    // All 0xFF: 130050 mod 256 = 2 per row.
    run_calc(32'hFFFF_FFFF, 16'hFFFF, 32'h0000_0202, 32'h0000_1B0E);
    wait_done();

    // Reset during BUSY cycle 2 aborts; nothing completes afterwards.
    @(negedge clk);
    i_matrix = 32'h0403_0201;
    i_vector = 16'h0605;
    i_calc   = 1'b1;
    @(negedge clk);
    i_calc = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("abort_ready", {31'd0, o_ready}, 32'd0);
    chk("abort_result", o_result, 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_completion", {31'd0, o_ready}, 32'd0);

    // Back-to-back: i_calc held high, one pulse every N+1 cycles.
    @(negedge clk);
    i_calc = 1'b1;
    s = cyc;
    for (int k = 1; k <= 3; k++) begin
      e.res = 32'h0000_2711;
      e.due = s + k * (N + 1);
      sb_q.push_back(e);
    end
    while (cyc < s + 3 * (N + 1)) begin
      @(negedge clk);
      if (cyc > s + N + 1) chk("b2b_result_const", o_result, 32'h0000_2711);
    end
    i_calc = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    chk("b2b_final_ready", {31'd0, o_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
